// File: rtl/systolic_drain.sv
// Snapshots the 16 accumulators of a 4x4 systolic array and drains them as a
// valid/ready stream. Define SYSTOLIC_DRAIN_REQUANT_EN for rounded, saturated 8-bit output.
module systolic_drain #(
    parameter int ACC_WIDTH = 32,
    parameter int NUM_ACC   = 16
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic                        capture,
    input  logic signed [ACC_WIDTH-1:0] c1,
    input  logic signed [ACC_WIDTH-1:0] c2,
    input  logic signed [ACC_WIDTH-1:0] c3,
    input  logic signed [ACC_WIDTH-1:0] c4,
    input  logic signed [ACC_WIDTH-1:0] c5,
    input  logic signed [ACC_WIDTH-1:0] c6,
    input  logic signed [ACC_WIDTH-1:0] c7,
    input  logic signed [ACC_WIDTH-1:0] c8,
    input  logic signed [ACC_WIDTH-1:0] c9,
    input  logic signed [ACC_WIDTH-1:0] c10,
    input  logic signed [ACC_WIDTH-1:0] c11,
    input  logic signed [ACC_WIDTH-1:0] c12,
    input  logic signed [ACC_WIDTH-1:0] c13,
    input  logic signed [ACC_WIDTH-1:0] c14,
    input  logic signed [ACC_WIDTH-1:0] c15,
    input  logic signed [ACC_WIDTH-1:0] c16,
    input  logic [4:0]                  shift_amt,
    output logic                        out_valid,
    input  logic                        out_ready,
    output logic signed [ACC_WIDTH-1:0] out_data,
    output logic [3:0]                  out_index,
    output logic                        out_last,
    output logic                        busy,
    output logic                        overrun
);

    localparam logic [3:0] LAST_IDX = 4'(NUM_ACC - 1);

    typedef enum logic {
        IDLE,
        DRAIN
    } state_t;

    state_t                      state_q, state_d;
    logic [3:0]                  index_q, index_d;
    logic                        overrun_q, overrun_d;
    logic                        load;
    logic                        xfer;
    logic signed [ACC_WIDTH-1:0] c_arr  [NUM_ACC];
    logic signed [ACC_WIDTH-1:0] bank_q [NUM_ACC];
    logic signed [ACC_WIDTH-1:0] bank_d [NUM_ACC];
    logic signed [ACC_WIDTH-1:0] sel_acc;
    logic signed [ACC_WIDTH-1:0] out_word;

    assign c_arr[0]  = c1;
    assign c_arr[1]  = c2;
    assign c_arr[2]  = c3;
    assign c_arr[3]  = c4;
    assign c_arr[4]  = c5;
    assign c_arr[5]  = c6;
    assign c_arr[6]  = c7;
    assign c_arr[7]  = c8;
    assign c_arr[8]  = c9;
    assign c_arr[9]  = c10;
    assign c_arr[10] = c11;
    assign c_arr[11] = c12;
    assign c_arr[12] = c13;
    assign c_arr[13] = c14;
    assign c_arr[14] = c15;
    assign c_arr[15] = c16;

    assign xfer = (state_q == DRAIN) && out_ready;

    always_comb begin
        state_d   = state_q;
        index_d   = index_q;
        overrun_d = overrun_q;
        load      = 1'b0;
        case (state_q)
            IDLE: begin
                if (capture) begin
                    load    = 1'b1;
                    index_d = '0;
                    state_d = DRAIN;
                end
            end
            DRAIN: begin
                if (xfer && (index_q == LAST_IDX)) begin
                    index_d = '0;
                    if (capture) begin
                        load = 1'b1;
                    end else begin
                        state_d = IDLE;
                    end
                end else begin
                    if (xfer) begin
                        index_d = index_q + 4'd1;
                    end
                    // A capture arriving mid-drain cannot be honoured without corrupting the bank.
                    if (capture) begin
                        overrun_d = 1'b1;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= IDLE;
            index_q   <= '0;
            overrun_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            index_q   <= index_d;
            overrun_q <= overrun_d;
        end
    end

    generate
        for (genvar gi = 0; gi < NUM_ACC; gi++) begin : g_bank
            always_comb begin
                bank_d[gi] = load ? c_arr[gi] : bank_q[gi];
            end

            always_ff @(posedge clk) begin
                if (reset) begin
                    bank_q[gi] <= '0;
                end else begin
                    bank_q[gi] <= bank_d[gi];
                end
            end
        end
    endgenerate

    assign sel_acc = bank_q[index_q];

`ifdef SYSTOLIC_DRAIN_REQUANT_EN
    // One extra bit keeps the rounding add from wrapping near the positive limit.
    logic signed [ACC_WIDTH:0] rq_round;
    logic signed [ACC_WIDTH:0] rq_sum;
    logic signed [ACC_WIDTH:0] rq_shifted;
    logic signed [ACC_WIDTH:0] rq_max;
    logic signed [ACC_WIDTH:0] rq_min;
    logic signed [7:0]         rq_sat;

    always_comb begin
        rq_max   = (ACC_WIDTH+1)'(127);
        rq_min   = -(ACC_WIDTH+1)'(128);
        rq_round = '0;
        if (shift_amt != 5'd0) begin
            rq_round = (ACC_WIDTH+1)'(1) << (shift_amt - 5'd1);
        end
        rq_sum     = {sel_acc[ACC_WIDTH-1], sel_acc} + rq_round;
        rq_shifted = rq_sum >>> shift_amt;
        if (rq_shifted > rq_max) begin
            rq_sat = 8'sd127;
        end else if (rq_shifted < rq_min) begin
            rq_sat = -8'sd128;
        end else begin
            rq_sat = rq_shifted[7:0];
        end
        out_word = {{(ACC_WIDTH-8){rq_sat[7]}}, rq_sat};
    end
`else
    logic unused_shift;
    assign unused_shift = ^shift_amt;
    assign out_word     = sel_acc;
`endif

    assign busy      = (state_q == DRAIN);
    assign out_valid = busy;
    assign out_index = index_q;
    assign out_last  = busy && (index_q == LAST_IDX);
    assign out_data  = busy ? out_word : '0;
    assign overrun   = overrun_q;

endmodule

// File: tb/tb_systolic_drain.sv
// Randomized scoreboard bench for systolic_drain; expected beats are queued per
// accepted snapshot and compared by an independent negedge monitor.
module tb_systolic_drain;

    localparam int W = 32;

    typedef struct {
        logic signed [W-1:0] acc;
        int                  idx;
    } beat_t;

    logic                clk;
    logic                reset;
    logic                capture;
    logic signed [W-1:0] c_sig [16];
    logic [4:0]          shift_amt;
    logic                out_valid;
    logic                out_ready;
    logic signed [W-1:0] out_data;
    logic [3:0]          out_index;
    logic                out_last;
    logic                busy;
    logic                overrun;

    int checks = 0;
    int errors = 0;
    int beats  = 0;

    beat_t               q[$];
    logic signed [W-1:0] c_drv  [16];
    logic signed [W-1:0] pend_c [16];
    bit                  pend_valid = 0;
    bit                  ovr_pend   = 0;
    bit                  rst_prev   = 1;
    bit                  exp_ovr    = 0;
    bit                  mon_en     = 0;

    systolic_drain #(.ACC_WIDTH(W), .NUM_ACC(16)) dut (
        .clk(clk), .reset(reset), .capture(capture),
        .c1(c_sig[0]), .c2(c_sig[1]), .c3(c_sig[2]), .c4(c_sig[3]),
        .c5(c_sig[4]), .c6(c_sig[5]), .c7(c_sig[6]), .c8(c_sig[7]),
        .c9(c_sig[8]), .c10(c_sig[9]), .c11(c_sig[10]), .c12(c_sig[11]),
        .c13(c_sig[12]), .c14(c_sig[13]), .c15(c_sig[14]), .c16(c_sig[15]),
        .shift_amt(shift_amt), .out_valid(out_valid), .out_ready(out_ready),
        .out_data(out_data), .out_index(out_index), .out_last(out_last),
        .busy(busy), .overrun(overrun)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic signed [63:0] act,
                         input logic signed [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Reference output: round-half-up, arithmetic shift, clamp to signed 8 bits.
    function automatic logic signed [W-1:0] ref_out(input logic signed [W-1:0] acc,
                                                    input logic [4:0] sh);
`ifdef SYSTOLIC_DRAIN_REQUANT_EN
        longint v;
        v = longint'(acc);
        if (sh != 0) v = v + (longint'(1) << (int'(sh) - 1));
        v = v >>> sh;
        if (v > 127) v = 127;
        if (v < -128) v = -128;
        return W'(v);
`else
        return acc;
`endif
    endfunction

    // Drive one cycle of inputs and decide, from the queued beats, whether a capture is taken.
    task automatic drive(input bit cap, input bit rdy, input bit rst);
        reset     = rst;
        capture   = cap;
        out_ready = rdy;
        for (int k = 0; k < 16; k++) c_sig[k] = c_drv[k];
        if (!rst && cap) begin
            if (q.size() == 0 || (q.size() == 1 && rdy)) begin
                pend_valid = 1;
                for (int k = 0; k < 16; k++) pend_c[k] = c_drv[k];
            end else begin
                ovr_pend = 1;
            end
        end
        rst_prev = rst;
    endtask

    task automatic advance();
        @(posedge clk);
        #1;
        if (rst_prev) begin
            q.delete();
            exp_ovr = 0;
        end else begin
            if (pend_valid) begin
                for (int k = 0; k < 16; k++) begin
                    beat_t b;
                    b.acc = pend_c[k];
                    b.idx = k;
                    q.push_back(b);
                end
            end
            if (ovr_pend) exp_ovr = 1;
        end
        pend_valid = 0;
        ovr_pend   = 0;
    endtask

    task automatic step(input bit cap, input bit rdy, input bit rst);
        drive(cap, rdy, rst);
        advance();
    endtask

    task automatic drain_wait();
        for (int i = 0; i < 200 && q.size() != 0; i++) step(0, 1, 0);
        check("drain_done", q.size(), 0);
    endtask

    always @(negedge clk) begin
        if (mon_en) begin
            check("out_valid", out_valid, q.size() != 0);
            check("busy", busy, q.size() != 0);
            check("overrun", overrun, exp_ovr);
            if (out_valid && q.size() != 0) begin
                check("out_data", out_data, ref_out(q[0].acc, shift_amt));
                check("out_index", out_index, q[0].idx);
                check("out_last", out_last, q[0].idx == 15);
                if (out_ready) begin
                    void'(q.pop_front());
                    beats++;
                end
            end
        end
    end

    initial begin
        int  b0;
        bit  done;
        shift_amt = 5'd4;
        for (int k = 0; k < 16; k++) c_drv[k] = '0;

        // Reset, with a capture that must be overridden
        step(1, 0, 1);
        step(1, 1, 1);
        @(negedge clk);
        check("rst_valid", out_valid, 0);
        check("rst_busy", busy, 0);
        check("rst_last", out_last, 0);
        check("rst_index", out_index, 0);
        check("rst_data", out_data, 0);
        check("rst_overrun", overrun, 0);
        mon_en = 1;

        // Basic drain
        for (int k = 0; k < 16; k++) c_drv[k] = (k + 1) * 1000;
        b0 = beats;
        step(1, 1, 0);
        drain_wait();
        step(0, 1, 0);
        check("basic_beats", beats - b0, 16);

        // Backpressure 1,0,0,1
        for (int k = 0; k < 16; k++) c_drv[k] = $urandom_range(0, 4000) - 2000;
        b0 = beats;
        step(1, 1, 0);
        for (int i = 0; i < 200 && q.size() != 0; i++) step(0, (i % 4 == 0) || (i % 4 == 3), 0);
        check("bp_beats", beats - b0, 16);

        // Back-to-back capture on the last transfer
        for (int k = 0; k < 16; k++) c_drv[k] = (k + 1) * 1000;
        step(1, 1, 0);
        done = 0;
        for (int i = 0; i < 60 && !done; i++) begin
            if (q.size() == 1) begin
                for (int k = 0; k < 16; k++) c_drv[k] = -(k + 1);
                step(1, 1, 0);
                done = 1;
            end else begin
                step(0, 1, 0);
            end
        end
        check("b2b_sent", done, 1);
        drain_wait();

        // Overrun at index 5
        for (int k = 0; k < 16; k++) c_drv[k] = $urandom;
        step(1, 1, 0);
        done = 0;
        for (int i = 0; i < 100 && q.size() != 0; i++) begin
            if (!done && q[0].idx == 5) begin
                for (int k = 0; k < 16; k++) c_drv[k] = $urandom;
                step(1, 1, 0);
                done = 1;
            end else begin
                step(0, 1'($urandom_range(0, 1)), 0);
            end
        end
        check("ovr_sent", done, 1);
        drain_wait();

        // Reset mid-drain at index 7
        step(1, 1, 0);
        done = 0;
        for (int i = 0; i < 60 && !done; i++) begin
            if (q.size() != 0 && q[0].idx == 7) begin
                step(0, 1, 1);
                done = 1;
            end else begin
                step(0, 1, 0);
            end
        end
        check("mid_rst_sent", done, 1);
        step(0, 1, 0);
        for (int k = 0; k < 16; k++) c_drv[k] = $urandom;
        step(1, 1, 0);
        drain_wait();

`ifdef SYSTOLIC_DRAIN_REQUANT_EN
        // Requant corner values; shift drops to 0 for the -5 beat
        c_drv[0] = 1000; c_drv[1] = 3000; c_drv[2] = -3000; c_drv[3] = 24; c_drv[4] = -5;
        shift_amt = 5'd4;
        step(1, 1, 0);
        for (int i = 0; i < 100 && q.size() != 0; i++) begin
            shift_amt = (q[0].idx == 4) ? 5'd0 : 5'd4;
            step(0, 1, 0);
        end
        check("rq_done", q.size(), 0);
`endif

        // Random traffic
        for (int i = 0; i < 800; i++) begin
            for (int k = 0; k < 16; k++) c_drv[k] = $urandom;
            shift_amt = 5'($urandom_range(0, 31));
            step($urandom_range(0, 5) == 0, 1'($urandom_range(0, 1)), $urandom_range(0, 149) == 0);
        end
        drain_wait();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/systolic_drain.md
SYSTOLIC_DRAIN -- requirements
Module: systolic_drain

Interface
REQ-001 Parameter ACC_WIDTH, default 32: width of each accumulator input and of out_data.
REQ-002 Parameter NUM_ACC, default 16: accumulator count, fixed at 16 to match the 4x4 array; other values unsupported.
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 reset  input  1  synchronous, active-high reset.
REQ-005 capture  input  1  single-cycle request to snapshot the accumulators.
REQ-006 c1..c16  input  ACC_WIDTH each, signed  array results; c1 = row0/col0, c16 = row3/col3, row-major.
REQ-007 shift_amt  input  5  requantization right-shift; used only when SYSTOLIC_DRAIN_REQUANT_EN is defined.
REQ-008 out_valid  output  1  out_data/out_index/out_last are valid.
REQ-009 out_ready  input  1  downstream accepts the beat.
REQ-010 out_data  output  ACC_WIDTH, signed  current result word.
REQ-011 out_index  output  4  accumulator index of the current beat, 0..15.
REQ-012 out_last  output  1  high only on the beat with out_index = 15.
REQ-013 busy  output  1  high while a drain is in progress.
REQ-014 overrun  output  1  sticky flag: a capture was dropped.

Function
REQ-015 Two states: IDLE and DRAIN; busy = (state == DRAIN); out_valid = busy.
REQ-016 IDLE + capture: at that edge, latch c1..c16 into a 16-entry snapshot bank, set index to 0, go to DRAIN.
REQ-017 Latency: capture sampled at edge N gives out_valid = 1 with out_index = 0 from edge N onward.
REQ-018 A beat transfers when out_valid && out_ready; index increments by 1 on each transfer.
REQ-019 While out_valid && !out_ready, out_data, out_index and out_last stay stable.
REQ-020 Transfer with index 15: return to IDLE unless a capture occurs in the same cycle (REQ-021).
REQ-021 Capture in the same cycle as the index-15 transfer: new snapshot accepted, index set to 0, state stays DRAIN; no idle bubble.
REQ-022 Capture in DRAIN at any other time: ignored; snapshot and index unchanged; overrun set to 1 and held until reset.
REQ-023 Snapshot bank is written only at accepted captures and never changes during a drain.
REQ-024 out_data is a registered or bank-indexed mux of the snapshot: no combinational path from c1..c16 to out_data.
REQ-025 out_ready has no effect in IDLE.

Reset
REQ-026 With reset asserted at an edge: state = IDLE, index = 0, overrun = 0, snapshot bank = 0.
REQ-027 Reset-state outputs: out_valid = 0, busy = 0, out_last = 0, out_index = 0, out_data = 0.
REQ-028 Reset overrides capture in the same cycle.
REQ-029 Reset mid-drain discards remaining beats, with no partial-last beat.

Configuration
REQ-030 Macro SYSTOLIC_DRAIN_REQUANT_EN defined: out_data = sat8((acc + R) >>> shift_amt), sign-extended to ACC_WIDTH.
- R = 2^(shift_amt-1) when shift_amt > 0, else 0.
- Arithmetic shift; the add is computed at ACC_WIDTH+1 bits with no wrap.
- sat8 clamps to [-128, 127].
REQ-031 Macro SYSTOLIC_DRAIN_REQUANT_EN undefined: out_data = raw snapshot accumulator; shift_amt ignored; no requant logic is synthesized.
REQ-032 Requant is applied at the output mux; handshake timing is identical in both builds.

Verification
REQ-033 Basic: c_k = k*1000 for k = 1..16, capture pulse, out_ready = 1 -> 16 consecutive beats, data 1000..16000, index 0..15, out_last only on index 15, busy low the cycle after.
REQ-034 Backpressure: out_ready toggles 1,0,0,1 pattern -> no beat lost or duplicated; outputs stable during stalls; 16 beats total.
REQ-035 Back-to-back: second capture with c_k = -k, asserted with the index-15 transfer -> next beat is index 0, data -1, no bubble.
REQ-036 Overrun: capture at index 5 with changed inputs -> beats 5..15 keep the original values, overrun = 1 until reset.
REQ-037 Reset mid-drain at index 7 -> next cycle out_valid = 0, overrun = 0; a new capture drains from index 0.
REQ-038 REQUANT_EN, shift_amt = 4: acc = 1000 -> 63; acc = 3000 -> 127; acc = -3000 -> -128; acc = 24 -> 2; shift_amt = 0, acc = -5 -> -5.
